// File: rtl/data_mem_bytes_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
// Big-endian lanes: mask bit k selects byte offset k, where offset 0 is the word MSB.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bits shifted past the word width mark an access that overruns the word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_BYTE:   base = 8'h01;
            SZ_HALF:   base = 8'h03;
            SZ_WORD:   base = 8'h0F;
            SZ_DOUBLE: base = 8'hFF;
            default:   base = 8'h00;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/data_mem_bytes_lane_align.sv
// Combinational lane steering: merges store bytes into a word and extracts/extends loads.
// The load result is taken from the merged word on stores so it reflects the post-store value.
module mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [1:0]                    size_i,
    input  logic [$clog2(DATA_BITS/8)-1:0] offset_i,
    input  logic                          unsigned_i,
    input  logic                          write_i,
    input  logic [DATA_BITS-1:0]          wdata_i,
    input  logic [DATA_BITS-1:0]          word_i,
    output logic [DATA_BITS-1:0]          wr_word_o,
    output logic [DATA_BITS-1:0]          result_o,
    output logic                          err_o
);
    localparam int NB = DATA_BITS / 8;

    logic [7:0]           mask8_s;
    logic [2:0]           align_s;
    logic [DATA_BITS-1:0] src_s;
    logic                 sign_s;
    int                   n_s;
    int                   off_s;

    // Access geometry and error detection.
    always_comb begin
        mask8_s = lane_mask(size_i, 3'(offset_i));
        off_s   = int'(offset_i);
        case (size_i)
            SZ_BYTE: begin n_s = 1; align_s = 3'b000; end
            SZ_HALF: begin n_s = 2; align_s = 3'b001; end
            SZ_WORD: begin n_s = 4; align_s = 3'b011; end
            default: begin n_s = 8; align_s = 3'b111; end
        endcase
        err_o = (|(3'(offset_i) & align_s)) | (|(mask8_s >> NB));
    end

    // Store merge: value byte j (from LSB) lands in lane off+n-1-j.
    always_comb begin
        wr_word_o = word_i;
        for (int k = 0; k < NB; k++) begin
            if (mask8_s[k] && (off_s + n_s - 1 - k) < NB) begin
                wr_word_o[DATA_BITS-1-8*k -: 8] = wdata_i[8*(off_s + n_s - 1 - k) +: 8];
            end else begin
                wr_word_o[DATA_BITS-1-8*k -: 8] = word_i[DATA_BITS-1-8*k -: 8];
            end
        end
    end

    // Load extraction with sign or zero fill above the accessed bytes.
    always_comb begin
        src_s    = write_i ? wr_word_o : word_i;
        sign_s   = src_s[DATA_BITS-1-8*off_s] & ~unsigned_i;
        result_o = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < n_s && (off_s + n_s - 1 - j) < NB) begin
                result_o[8*j +: 8] = src_s[DATA_BITS-1-8*(off_s + n_s - 1 - j) -: 8];
            end else begin
                result_o[8*j +: 8] = {8{sign_s}};
            end
        end
    end

endmodule

// File: rtl/data_mem_bytes.sv
// Single-port byte-addressable data memory with hardware zero-init and 1-cycle response.
module data_mem_bytes
    import data_mem_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic                 resp_err
);
    localparam int OFF_BITS = $clog2(DATA_BITS / 8);
    localparam int IDX_BITS = ADDR_BITS - OFF_BITS;
    localparam int DEPTH    = 1 << IDX_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [DATA_BITS-1:0] resp_rdata_q, resp_rdata_d;

    logic [IDX_BITS-1:0]  req_idx_s;
    logic [OFF_BITS-1:0]  req_off_s;
    logic [DATA_BITS-1:0] word_s, wr_word_s, result_s, mem_wdata_s;
    logic [IDX_BITS-1:0]  mem_idx_s;
    logic                 err_s, accept_s, mem_we_s;

    assign req_idx_s = req_addr[ADDR_BITS-1:OFF_BITS];
    assign req_off_s = req_addr[OFF_BITS-1:0];
    assign word_s    = mem_q[req_idx_s];

    mem_lane_align #(
        .DATA_BITS(DATA_BITS)
    ) u_align (
        .size_i    (req_size),
        .offset_i  (req_off_s),
        .unsigned_i(req_unsigned),
        .write_i   (req_write),
        .wdata_i   (req_wdata),
        .word_i    (word_s),
        .wr_word_o (wr_word_s),
        .result_o  (result_s),
        .err_o     (err_s)
    );

    // FSM next state, array write port and response next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_idx_s   = req_idx_s;
        mem_wdata_s = wr_word_s;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = ~rst;
                mem_idx_s   = cnt_q;
                mem_wdata_s = '0;
                cnt_d       = cnt_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                accept_s = req_valid;
                mem_we_s = req_valid & req_write & ~err_s;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        ready_d      = (state_d == ST_RUN);
        resp_valid_d = accept_s;
        if (accept_s) begin
            resp_err_d   = err_s;
            resp_rdata_d = err_s ? '0 : result_s;
        end else begin
            resp_err_d   = resp_err_q;
            resp_rdata_d = resp_rdata_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Storage array; cleared only by the INIT sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
